// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the instruction/data RAM port arbiter.
package mem_arb_pkg;

  typedef enum logic {IDLE = 1'b0, RMW_WRITE = 1'b1} state_t;
  typedef enum logic {INSTR = 1'b0, DATA = 1'b1} req_id_t;

  localparam int WORD_BYTES = 4;

  // Take byte k from new_w where be[k] is set, otherwise keep old_w.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: bit 0 = instruction port, bit 1 = data port.
module mem_rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  req_id_t rr_last_q, rr_last_d;

  always_comb begin
    gnt_o     = 2'b00;
    rr_last_d = rr_last_q;
    if (en_i) begin
      // On a tie the port that was not granted last wins.
      if (req_i == 2'b11) gnt_o = (rr_last_q == DATA) ? 2'b01 : 2'b10;
      else                gnt_o = req_i;
      if (gnt_o[0])      rr_last_d = INSTR;
      else if (gnt_o[1]) rr_last_d = DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_last_q <= DATA;
    else     rr_last_q <= rr_last_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-enable-less RAM between fetch and load/store ports;
// partial writes become a read-modify-write over two cycles.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int RAM_DEPTH = 1024,
  parameter int ADDR_W    = $clog2(RAM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  output logic              ram_regce,
  input  logic [31:0]       ram_dout
);

  state_t              state_q, state_d;
  logic [1:0]          gnt;
  logic                i_oor, d_oor, d_part;
  logic [ADDR_W-1:0]   rmw_addr_q;
  logic [3:0]          rmw_be_q;
  logic [31:0]         rmw_wdata_q;
  logic                i_rvalid_q, i_err_q, d_rvalid_q, d_err_q, d_wr_q;
  logic [31:0]         i_hold_q, d_hold_q;
  logic                unused_addr_lsb;

  assign unused_addr_lsb = ^{i_addr[1:0], d_addr[1:0]};

  mem_rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en_i  (!rst && state_q == IDLE),
    .req_i ({d_req, i_req}),
    .gnt_o (gnt)
  );

  assign i_gnt     = gnt[0];
  assign d_gnt     = gnt[1];
  assign ram_regce = 1'b1;
  assign i_oor     = |i_addr[31:ADDR_W+2];
  assign d_oor     = |d_addr[31:ADDR_W+2];
  assign d_part    = d_we && (d_be != 4'h0) && (d_be != 4'hF);

  always_comb begin
    state_d  = state_q;
    ram_addr = '0;
    ram_din  = '0;
    ram_we   = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (i_gnt && !i_oor) begin
            ram_addr = i_addr[ADDR_W+1:2];
          end else if (d_gnt && !d_oor) begin
            if (!d_we) begin
              ram_addr = d_addr[ADDR_W+1:2];
            end else if (d_be == 4'hF) begin
              ram_addr = d_addr[ADDR_W+1:2];
              ram_din  = d_wdata;
              ram_we   = 1'b1;
            end else if (d_be != 4'h0) begin
              ram_addr = d_addr[ADDR_W+1:2];
              state_d  = RMW_WRITE;
            end
          end
        end
        RMW_WRITE: begin
          ram_addr = rmw_addr_q;
          ram_din  = byte_merge(ram_dout, rmw_wdata_q, rmw_be_q);
          ram_we   = 1'b1;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Read data arrives from the RAM in the response cycle; the hold
  // registers keep the last presented value while rvalid is low.
  assign i_rvalid = i_rvalid_q;
  assign i_err    = i_err_q;
  assign i_rdata  = i_rvalid_q ? (i_err_q ? 32'h0 : ram_dout) : i_hold_q;
  assign d_rvalid = d_rvalid_q;
  assign d_err    = d_err_q;
  assign d_rdata  = d_rvalid_q ? ((d_err_q || d_wr_q) ? 32'h0 : ram_dout) : d_hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rmw_addr_q  <= '0;
      rmw_be_q    <= '0;
      rmw_wdata_q <= '0;
      i_rvalid_q  <= 1'b0;
      i_err_q     <= 1'b0;
      i_hold_q    <= '0;
      d_rvalid_q  <= 1'b0;
      d_err_q     <= 1'b0;
      d_wr_q      <= 1'b0;
      d_hold_q    <= '0;
    end else begin
      state_q    <= state_d;
      i_rvalid_q <= i_gnt;
      if (i_gnt) i_err_q <= i_oor;
      if (i_rvalid_q) i_hold_q <= i_rdata;
      // In-range partial writes respond one cycle later, out of RMW_WRITE.
      d_rvalid_q <= (d_gnt && !(d_part && !d_oor)) || (state_q == RMW_WRITE);
      if (d_gnt) begin
        d_err_q     <= d_oor;
        d_wr_q      <= d_we;
        rmw_addr_q  <= d_addr[ADDR_W+1:2];
        rmw_be_q    <= d_be;
        rmw_wdata_q <= d_wdata;
      end
      if (d_rvalid_q) d_hold_q <= d_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural one-cycle-latency RAM.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk, rst;
  logic        i_req, i_gnt, i_rvalid, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din, ram_dout;
  logic        ram_we, ram_regce;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] mem [0:1023];

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_regce(ram_regce), .ram_dout(ram_dout)
  );

  // Clock / reset-free RAM model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial for (int k = 0; k < 1024; k++) mem[k] = k;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_be = 4'h0;
    i_addr = 32'h4; d_addr = 32'h8; d_wdata = 32'h0;
    settle();
    chk("rst_i_gnt", i_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_ram_we", ram_we, 0);
    tick();
    chk("rst_i_rvalid", i_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_i_gnt2", i_gnt, 0);
    tick();
    rst = 1'b0;
    settle();
    // Contention: I, D, I, D with word k = k
    chk("c0_i_gnt", i_gnt, 1);
    chk("c0_d_gnt", d_gnt, 0);
    chk("c0_ram_addr", ram_addr, 1);
    tick();
    chk("c1_i_rvalid", i_rvalid, 1);
    chk("c1_i_rdata", i_rdata, 1);
    chk("c1_d_gnt", d_gnt, 1);
    chk("c1_i_gnt", i_gnt, 0);
    chk("c1_ram_addr", ram_addr, 2);
    tick();
    chk("c2_d_rvalid", d_rvalid, 1);
    chk("c2_d_rdata", d_rdata, 2);
    chk("c2_i_rvalid", i_rvalid, 0);
    chk("c2_i_gnt", i_gnt, 1);
    tick();
    chk("c3_i_rdata", i_rdata, 1);
    chk("c3_d_gnt", d_gnt, 1);
    tick();
    i_req = 1'b0; d_req = 1'b0;
    settle();
    chk("c4_d_rvalid", d_rvalid, 1);
    chk("c4_d_rdata", d_rdata, 2);
    chk("c4_i_rdata_hold", i_rdata, 1);
    chk("c4_no_gnt", {i_gnt, d_gnt}, 0);
    tick();
    // Full write then read of 0x10
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h10; d_wdata = 32'hDEADBEEF;
    settle();
    chk("fw_d_gnt", d_gnt, 1);
    chk("fw_ram_we", ram_we, 1);
    chk("fw_ram_addr", ram_addr, 4);
    chk("fw_ram_din", ram_din, 32'hDEADBEEF);
    tick();
    d_we = 1'b0;
    settle();
    chk("fw_d_rvalid", d_rvalid, 1);
    chk("fw_d_rdata", d_rdata, 0);
    chk("fr_d_gnt", d_gnt, 1);
    chk("fr_ram_addr", ram_addr, 4);
    tick();
    d_req = 1'b0;
    settle();
    chk("fr_d_rvalid", d_rvalid, 1);
    chk("fr_d_rdata", d_rdata, 32'hDEADBEEF);
    tick();
    // Partial write: word 4 = 0x11223344, then be=0101 data AABBCCDD
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_wdata = 32'h11223344;
    settle();
    chk("pw_pre_ram_we", ram_we, 1);
    tick();
    d_be = 4'b0101; d_wdata = 32'hAABBCCDD;
    settle();
    chk("pw_d_gnt", d_gnt, 1);
    chk("pw_n_ram_we", ram_we, 0);
    chk("pw_n_ram_addr", ram_addr, 4);
    tick();
    d_req = 1'b0; i_req = 1'b1; i_addr = 32'h10;
    settle();
    chk("pw_rmw_i_gnt", i_gnt, 0);
    chk("pw_rmw_d_gnt", d_gnt, 0);
    chk("pw_rmw_ram_we", ram_we, 1);
    chk("pw_rmw_ram_addr", ram_addr, 4);
    chk("pw_rmw_ram_din", ram_din, 32'h11BB33DD);
    chk("pw_rmw_d_rvalid", d_rvalid, 0);
    tick();
    chk("pw_n2_d_rvalid", d_rvalid, 1);
    chk("pw_n2_d_rdata", d_rdata, 0);
    chk("pw_n2_i_gnt", i_gnt, 1);
    tick();
    i_req = 1'b0;
    settle();
    chk("pw_rd_i_rvalid", i_rvalid, 1);
    chk("pw_rd_i_rdata", i_rdata, 32'h11BB33DD);
    tick();
    // Out of range: instruction word 1024, then data write far away
    i_req = 1'b1; i_addr = 32'h0000_1000;
    settle();
    chk("oor_i_gnt", i_gnt, 1);
    chk("oor_i_ram_we", ram_we, 0);
    tick();
    i_req = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h8000_0010; d_wdata = 32'h12345678;
    settle();
    chk("oor_i_rvalid", i_rvalid, 1);
    chk("oor_i_err", i_err, 1);
    chk("oor_i_rdata", i_rdata, 0);
    chk("oor_d_gnt", d_gnt, 1);
    chk("oor_d_ram_we", ram_we, 0);
    tick();
    // Null write to word 4
    d_be = 4'h0; d_addr = 32'h10;
    settle();
    chk("oor_d_rvalid", d_rvalid, 1);
    chk("oor_d_err", d_err, 1);
    chk("oor_i_err_hold", i_err, 1);
    chk("nw_d_gnt", d_gnt, 1);
    chk("nw_ram_we", ram_we, 0);
    tick();
    d_req = 1'b0;
    settle();
    chk("nw_d_rvalid", d_rvalid, 1);
    chk("nw_d_err", d_err, 0);
    chk("nw_mem4", mem[4], 32'h11BB33DD);
    tick();
    // Reset in the RMW_WRITE cycle
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h10; d_wdata = 32'hFFFFFFFF;
    settle();
    chk("rr_d_gnt", d_gnt, 1);
    tick();
    d_req = 1'b0; rst = 1'b1;
    settle();
    chk("rr_ram_we", ram_we, 0);
    chk("rr_d_rvalid", d_rvalid, 0);
    tick();
    rst = 1'b0;
    settle();
    chk("rr_post_d_rvalid", d_rvalid, 0);
    chk("rr_state", 32'(dut.state_q), 32'(IDLE));
    chk("rr_mem4", mem[4], 32'h11BB33DD);
    i_req = 1'b1; i_addr = 32'h10;
    settle();
    chk("rr_i_gnt", i_gnt, 1);
    tick();
    i_req = 1'b0;
    settle();
    chk("rr_later_d_rvalid", d_rvalid, 0);
    chk("rr_i_rdata", i_rdata, 32'h11BB33DD);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
